spike_event_logger: RTL

// - Downstream of the HH neuron pair and STDP synapse: takes spike levels (pre = neuron1, post = neuron2).
// - Detects rising edges on both spike levels.
// - Tags each event with a free-running timestamp and queues it in a FIFO.
// - Host drains the FIFO via a valid/ready port; per-source spike counts and drop statistics are kept.

---
 rtl/spike_event_logger.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spike_event_logger.sv
// Spike event logger: edge-detects pre/post spike levels, timestamps them,
// queues records in a FWFT FIFO and keeps per-source and drop statistics.
module spike_event_logger #(
    parameter int unsigned TS_BITS  = 14,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_BITS = 8,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned RW      = TS_BITS + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pre_spike,
    input  logic                post_spike,
    output logic [RW-1:0]       rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [AW:0]         level,
    output logic                overflow,
    input  logic                clear_stats,
    output logic [CNT_BITS-1:0] drop_count,
    output logic [CNT_BITS-1:0] pre_count,
    output logic [CNT_BITS-1:0] post_count
);

    logic               pre_q;
    logic               post_q;
    logic [TS_BITS-1:0] ts;
    logic [RW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    logic          pre_edge;
    logic          post_edge;
    logic          event_hit;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [RW-1:0] record;

    // Event detection, record formation and FIFO push/pop/drop decisions
    always_comb begin
        pre_edge  = enable & pre_spike & ~pre_q;
        post_edge = enable & post_spike & ~post_q;
        event_hit = pre_edge | post_edge;
        record    = {post_edge, pre_edge, ts};
        full      = (count == (AW+1)'(DEPTH));
        pop       = rd_ready & (count != '0);
        push      = event_hit & (~full | pop);
        drop      = event_hit & full & ~pop;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign level    = count;

    // Edge registers follow the inputs every cycle, even when disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= 1'b0;
            post_q <= 1'b0;
        end else begin
            pre_q  <= pre_spike;
            post_q <= post_spike;
        end
    end

    // Free-running timestamp, frozen while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else if (enable) begin
            ts <= ts + 1'b1;
        end
    end

    // FIFO storage; contents are masked at the output when empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= record;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics; clear_stats overrides any same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            pre_count  <= '0;
            post_count <= '0;
        end else begin
            if (pre_edge)  pre_count  <= pre_count + 1'b1;
            if (post_edge) post_count <= post_count + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule
